// File: rtl/img_packer_121_if.sv
// Pixel-stream input and packed-image output of img_packer_121, grouped as one bundle.
// slave = the packer, master = pixel source plus image consumer.
interface img_packer_121_if #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 121
);
  logic [PIX_W-1:0]       pix_in;
  logic                   pix_valid;
  logic                   pix_sof;
  logic                   pix_ready;
  logic [PIX_W*N_PIX-1:0] img_source;
  logic                   valid_top;
  logic                   ready_top;
  logic                   sof_err;

  modport slave (
    input  pix_in, pix_valid, pix_sof, ready_top,
    output pix_ready, img_source, valid_top, sof_err
  );

  modport master (
    output pix_in, pix_valid, pix_sof, ready_top,
    input  pix_ready, img_source, valid_top, sof_err
  );
endinterface

// File: rtl/img_packer_121.sv
// Packs a 121-pixel stream MSB-first into one wide image; image valid 1 cycle after last pixel.
// A finished image waits in the assembly buffer (pix_ready low) while the output is still occupied.
module img_packer_121 #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 121
) (
  input logic              clk,
  input logic              rst,
  img_packer_121_if.slave  bus
);
  localparam int IMG_W = PIX_W * N_PIX;
  localparam int CNT_W = $clog2(N_PIX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PIX - 1);

  typedef enum logic {FILL, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [IMG_W-1:0] asm_buf;
  logic [IMG_W-1:0] asm_nxt;
  logic             live;
  logic             accept;
  logic             complete;
  logic             out_free;
  logic             load_asm;
  logic             load_buf;

  // live keeps pix_ready low until the first edge after reset is released
  assign bus.pix_ready = live && (state == FILL);
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign idx           = bus.pix_sof ? '0 : cnt;
  assign complete      = accept && (idx == LAST);
  assign out_free      = !bus.valid_top || bus.ready_top;

  always_comb begin
    asm_nxt = asm_buf;
    asm_nxt[(N_PIX - 1 - int'(idx)) * PIX_W +: PIX_W] = bus.pix_in;
  end

  always_comb begin
    state_nxt = state;
    load_asm  = 1'b0;
    load_buf  = 1'b0;
    case (state)
      FILL: begin
        if (complete) begin
          if (out_free) load_asm = 1'b1;
          else          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (out_free) begin
          load_buf  = 1'b1;
          state_nxt = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      live           <= 1'b0;
      cnt            <= '0;
      asm_buf        <= '0;
      bus.img_source <= '0;
      bus.valid_top  <= 1'b0;
      bus.sof_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      live        <= 1'b1;
      bus.sof_err <= accept && bus.pix_sof && (cnt != '0);
      if (accept) begin
        asm_buf <= asm_nxt;
        cnt     <= complete ? '0 : idx + 1'b1;
      end
      if (load_asm) begin
        bus.img_source <= asm_nxt;
        bus.valid_top  <= 1'b1;
      end else if (load_buf) begin
        bus.img_source <= asm_buf;
        bus.valid_top  <= 1'b1;
      end else if (bus.valid_top && bus.ready_top) begin
        bus.valid_top  <= 1'b0;
      end
    end
  end
endmodule
